// File: rtl/gcd_operand_fifo.sv
// Operand-pair FIFO feeding a GCD unit: registered valid/ready on both sides,
// no bypass, head entry shown combinationally from storage.
module gcd_operand_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [W-1:0]               in_bits_A,
   input  logic [W-1:0]               in_bits_B,
   input  logic                       in_val,
   output logic                       in_rdy,
   output logic [W-1:0]               operands_bits_A,
   output logic [W-1:0]               operands_bits_B,
   output logic                       operands_val,
   input  logic                       operands_rdy,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [15:0]                dispatched
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_a_q [DEPTH];
   logic [W-1:0]  mem_a_d [DEPTH];
   logic [W-1:0]  mem_b_q [DEPTH];
   logic [W-1:0]  mem_b_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   dispatched_q, dispatched_d;
   logic          enq, deq;

   // Handshake flags come only from registered occupancy, so neither side
   // sees a combinational path from the other.
   assign full            = (count_q == CW'(DEPTH));
   assign empty           = (count_q == '0);
   assign in_rdy          = !full;
   assign operands_val    = !empty;
   assign operands_bits_A = mem_a_q[rd_ptr_q];
   assign operands_bits_B = mem_b_q[rd_ptr_q];
   assign count           = count_q;
   assign dispatched      = dispatched_q;

   assign enq = in_val && in_rdy;
   assign deq = operands_val && operands_rdy;

   always_comb begin
      mem_a_d      = mem_a_q;
      mem_b_d      = mem_b_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dispatched_d = dispatched_q;
      if (enq) begin
         mem_a_d[wr_ptr_q] = in_bits_A;
         mem_b_d[wr_ptr_q] = in_bits_B;
         wr_ptr_d          = wr_ptr_q + AW'(1);
      end
      if (deq) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         dispatched_d = dispatched_q + 16'd1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dispatched_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i] <= '0;
            mem_b_q[i] <= '0;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dispatched_q <= dispatched_d;
         mem_a_q      <= mem_a_d;
         mem_b_q      <= mem_b_d;
      end
   end

endmodule

// File: tb/tb_gcd_operand_fifo.sv
// Randomised bench for gcd_operand_fifo against a queue-based reference model.
module tb_gcd_operand_fifo;

   localparam int W     = 128;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  in_bits_A = '0, in_bits_B = '0;
   logic          in_val = 1'b0, operands_rdy = 1'b0;
   logic          in_rdy, operands_val, full, empty;
   logic [W-1:0]  operands_bits_A, operands_bits_B;
   logic [CW-1:0] count;
   logic [15:0]   dispatched;

   gcd_operand_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_bits_A(in_bits_A), .in_bits_B(in_bits_B), .in_val(in_val), .in_rdy(in_rdy),
      .operands_bits_A(operands_bits_A), .operands_bits_B(operands_bits_B),
      .operands_val(operands_val), .operands_rdy(operands_rdy),
      .count(count), .full(full), .empty(empty), .dispatched(dispatched)
   );

   always #5 clk = ~clk;

   int             n_vec = 0;
   int             n_bad = 0;
   logic [2*W-1:0] mq[$];
   int             disp = 0;
   bit             rst_seen = 0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_w();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_all();
      int sz = mq.size();
      chk("in_rdy", W'(in_rdy), W'(sz < DEPTH));
      chk("op_val", W'(operands_val), W'(sz > 0));
      chk("count", W'(count), W'(sz));
      chk("full", W'(full), W'(sz == DEPTH));
      chk("empty", W'(empty), W'(sz == 0));
      chk("dispatched", W'(dispatched), W'(disp % 65536));
      if (sz > 0) begin
         chk("head_a", operands_bits_A, mq[0][2*W-1:W]);
         chk("head_b", operands_bits_B, mq[0][W-1:0]);
      end else if (rst_seen) begin
         chk("rst_a", operands_bits_A, '0);
         chk("rst_b", operands_bits_B, '0);
      end
   endtask

   // Drive one cycle's inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input logic r, input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy);
      reset = r; in_val = iv; in_bits_A = a; in_bits_B = b; operands_rdy = ordy;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         disp = 0;
         rst_seen = 1;
      end else begin
         bit e = iv && (mq.size() < DEPTH);
         bit d = (mq.size() > 0) && ordy;
         if (d) begin
            void'(mq.pop_front());
            disp++;
         end
         if (e) mq.push_back({a, b});
         rst_seen = 0;
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int sent, got, guard;
      logic iv, rdy;

      cycle(0, 1, W'(5), W'(6), 1);
      chk("rst_rdy", W'(in_rdy), W'(1));
      chk("rst_val", W'(operands_val), W'(0));

      // single pair
      cycle(1, 1, W'(27), W'(15), 0);
      chk("s_a", operands_bits_A, W'(27));
      chk("s_b", operands_bits_B, W'(15));
      chk("s_cnt", W'(count), W'(1));
      cycle(1, 0, '0, '0, 1);
      chk("s_empty", W'(empty), W'(1));
      chk("s_disp", W'(dispatched), W'(1));

      // fill, then hold a fifth pair
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, W'(100 + i), W'(200 + i), 0);
      chk("f_full", W'(full), W'(1));
      chk("f_rdy", W'(in_rdy), W'(0));
      cycle(1, 1, W'(555), W'(666), 0);
      chk("f_cnt", W'(count), W'(DEPTH));
      chk("f_head", operands_bits_A, W'(100));
      cycle(1, 1, W'(555), W'(666), 1);
      chk("fs_cnt", W'(count), W'(DEPTH - 1));
      chk("fs_rdy", W'(in_rdy), W'(1));
      cycle(1, 1, W'(555), W'(666), 0);
      chk("fs_acc", W'(count), W'(DEPTH));

      // reset mid-operation with count=3
      cycle(1, 0, '0, '0, 1);
      chk("r_pre", W'(count), W'(3));
      cycle(0, 1, W'(777), W'(888), 1);
      chk("r_cnt", W'(count), W'(0));
      chk("r_val", W'(operands_val), W'(0));
      chk("r_rdy", W'(in_rdy), W'(1));
      chk("r_disp", W'(dispatched), W'(0));
      cycle(1, 0, '0, '0, 1);
      chk("r_noval", W'(operands_val), W'(0));

      // ordered stream of 10 pairs with random stalls
      sent = 0; got = 0; guard = 0;
      while (got < 10 && guard < 500) begin
         iv  = (sent < 10) && ($urandom_range(0, 2) != 0);
         rdy = $urandom_range(0, 1) == 1;
         if (mq.size() > 0 && rdy) begin
            chk("ord_a", operands_bits_A, W'(got));
            chk("ord_b", operands_bits_B, W'(got + 1));
            got++;
         end
         if (iv && mq.size() < DEPTH) begin
            cycle(1, 1, W'(sent), W'(sent + 1), rdy);
            sent++;
         end else begin
            cycle(1, iv, W'(sent), W'(sent + 1), rdy);
         end
         guard++;
      end
      chk("strm_got", W'(got), W'(10));
      chk("strm_disp", W'(dispatched), W'(10));

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 49) != 0), $urandom_range(0, 1), rnd_w(), rnd_w(),
               $urandom_range(0, 1));

      // dispatched counter wrap
      cycle(0, 0, '0, '0, 0);
      guard = 0;
      while (disp < 65536 && guard < 70000) begin
         cycle(1, 1, rnd_w(), rnd_w(), 1);
         guard++;
      end
      chk("wrap_n", W'(disp), W'(65536));
      chk("wrap", W'(dispatched), W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
